pe_dbuf: RTL and testbench
==========================

Name: pe_dbuf

Overview:
Next-generation systolic-array processing element: signed fixed-point multiply-accumulate with parametrised width and fraction bits, a double-buffered (shadow/active) weight register, and valid propagation.
- Weights for the next tile shift down the column through a shadow chain while the current tile computes.
- Active weights swap in on a one-cycle switch pulse that propagates with the data wavefront.
- Arithmetic saturates and raises a sticky overflow flag.
- Sits in the systolic array grid: inputs flow left to right, psums and weights flow top to bottom.

Parameters:
- DATA_WIDTH, 16, width of input, weight and psum (two's complement).
- FRAC_BITS, 8, fraction bits of the Q format; 0 <= FRAC_BITS < DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  input_in/psum_in valid this cycle.
- input_in  in  DATA_WIDTH  activation from left neighbour.
- psum_in  in  DATA_WIDTH  partial sum from above.
- load_weight  in  1  shift enable for the weight chain.
- weight_in  in  DATA_WIDTH  weight from above (shadow chain).
- switch_in  in  1  pulse: copy shadow into active weight.
- clear_flag  in  1  clears sat_flag.
- valid_out  out  1  registered valid_in.
- input_out  out  DATA_WIDTH  registered activation to right neighbour.
- psum_out  out  DATA_WIDTH  registered saturated MAC result.
- weight_out  out  DATA_WIDTH  shadow register value, to PE below.
- switch_out  out  1  registered switch_in, to right neighbour.
- sat_flag  out  1  sticky: a saturation has occurred.

Behaviour:
- All state updates on posedge clk. With rst=1, every register clears to 0 on that edge: valid_out, input_out, psum_out, weight_out (shadow), active weight, switch_out, sat_flag. Reset overrides all other inputs, including mid-operation.
- Shadow chain: if load_weight=1, shadow <= weight_in. Otherwise it holds. weight_out = shadow, so an N-deep column loads in N cycles.
- Switch: if switch_in=1, active <= shadow (pre-edge value).
  - switch_in and load_weight in the same cycle: active gets the OLD shadow, shadow gets weight_in.
- switch_out <= switch_in every cycle, independent of valid_in. This gives a 1-cycle skew per column.
- MAC, combinational then registered, latency 1 cycle:
  - prod = input_in * active as a full 2*DATA_WIDTH signed product.
  - scaled = prod >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - scaled saturates to [-2^(DW-1), 2^(DW-1)-1].
  - sum = saturated scaled + psum_in, computed at DATA_WIDTH+1 bits, then saturated to DATA_WIDTH.
- The active weight used in a MAC is the value before any same-edge switch. A switch takes effect on the following cycle's data.
- valid_out <= valid_in every cycle.
- If valid_in=1: input_out <= input_in and psum_out <= sum. If valid_in=0: input_out and psum_out hold their values.
- sat_flag:
  - Set when valid_in=1 and either saturation stage clips.
  - clear_flag=1 clears it, but a same-cycle set wins, so the flag ends at 1.
  - Holds otherwise.
  - Clipping with valid_in=0 does not set it.
- Weight load and switch are accepted regardless of valid_in. They never disturb psum_out or input_out.
- No state machine beyond the registers above. Weight loading and computation may overlap without restriction.

Test Plan (DATA_WIDTH=16, FRAC_BITS=8):
1. Reset and basic MAC:
   - Stimulus: rst 1 cycle; load_weight with weight_in=0x0200 (2.0); switch_in pulse; then valid_in=1, input_in=0x0180 (1.5), psum_in=0x0100.
   - Required: psum_out=0x0400 and valid_out=1 one cycle later; input_out=0x0180; sat_flag=0; all outputs 0 right after reset.
2. Double buffering:
   - Stimulus: active=0x0100. Load shadow with 0x0300 while streaming valid inputs of 0x0100 (psum_in=0); then switch_in.
   - Required: psum_out stays 0x0100 until the cycle after switch_in, then becomes 0x0300.
   - Required: switch_out pulses exactly 1 cycle after switch_in; weight_out=0x0300 after load.
3. Negative and truncation:
   - Stimulus: weight 0x0080 (0.5); input 0xFF00 (-1.0), psum 0. Then input 0xFFFF (-1/256).
   - Required: 0xFF80, then 0xFFFF (floor of -1/512).
4. Saturation and sticky flag:
   - Stimulus: weight 0x0200; input 0x7F00, psum 0.
   - Required: psum_out=0x7FFF, sat_flag=1.
   - Stimulus: next cycle input 0x0100 with psum_in=0x8000.
   - Required: psum_out=0x8200, sat_flag still 1.
   - Stimulus: clear_flag=1 with a clipping input.
   - Required: flag remains 1. A clear without clipping drops it to 0.
5. Valid gating and simultaneous events:
   - Stimulus: valid_in=0 with changing input_in.
   - Required: psum_out/input_out hold, valid_out=0.
   - Stimulus: load_weight and switch_in in the same cycle.
   - Required: active=old shadow, shadow=new weight_in.
6. Reset mid-operation:
   - Stimulus: assert rst during streaming with a loaded shadow.
   - Required: all outputs and both weight registers are 0 on the next edge; the first post-reset valid MAC yields psum_out=psum_in.

Source files
------------

// File: rtl/pe_dbuf.sv
// Systolic-array PE: signed fixed-point saturating MAC with a
// double-buffered (shadow/active) weight and a switch wavefront.
module pe_dbuf #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] input_in,
  input  logic [DATA_WIDTH-1:0] psum_in,
  input  logic                  load_weight,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic                  switch_in,
  input  logic                  clear_flag,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] input_out,
  output logic [DATA_WIDTH-1:0] psum_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  switch_out,
  output logic                  sat_flag
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]        shadow;
  logic [DW-1:0]        active;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic [PW-DW:0]       top;
  logic                 clip1;
  logic [DW-1:0]        sat1;
  logic [DW:0]          sum;
  logic                 clip2;
  logic [DW-1:0]        sum_sat;

  assign weight_out = shadow;

  // Upper bits of the scaled product must all match the DW-1 sign bit
  always_comb begin
    a_ext   = PW'($signed(input_in));
    w_ext   = PW'($signed(active));
    prod    = a_ext * w_ext;
    scaled  = prod >>> FRAC_BITS;
    top     = scaled[PW-1:DW-1];
    clip1   = !((&top) || (~|top));
    sat1    = clip1 ? (scaled[PW-1] ? SMIN : SMAX)
                    : scaled[DW-1:0];
    sum     = {sat1[DW-1], sat1} + {psum_in[DW-1], psum_in};
    clip2   = sum[DW] ^ sum[DW-1];
    sum_sat = clip2 ? (sum[DW] ? SMIN : SMAX) : sum[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      input_out  <= '0;
      psum_out   <= '0;
      shadow     <= '0;
      active     <= '0;
      switch_out <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      valid_out  <= valid_in;
      switch_out <= switch_in;
      if (load_weight)
        shadow <= weight_in;
      if (switch_in)
        active <= shadow;
      if (valid_in) begin
        input_out <= input_in;
        psum_out  <= sum_sat;
      end
      // A same-cycle clip beats clear_flag
      if (valid_in && (clip1 || clip2))
        sat_flag <= 1'b1;
      else if (clear_flag)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbuf.sv
// Scoreboard bench for pe_dbuf: directed vectors, queued expected
// psum/input results checked by an independent output monitor.
module tb_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] input_in;
  logic [15:0] psum_in;
  logic        load_weight;
  logic [15:0] weight_in;
  logic        switch_in;
  logic        clear_flag;
  logic        valid_out;
  logic [15:0] input_out;
  logic [15:0] psum_out;
  logic [15:0] weight_out;
  logic        switch_out;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  pe_dbuf #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .input_in(input_in),
    .psum_in(psum_in), .load_weight(load_weight),
    .weight_in(weight_in), .switch_in(switch_in),
    .clear_flag(clear_flag), .valid_out(valid_out),
    .input_out(input_out), .psum_out(psum_out),
    .weight_out(weight_out), .switch_out(switch_out),
    .sat_flag(sat_flag)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge
  task automatic step(input logic r, input logic v,
                      input logic [15:0] in, input logic [15:0] ps,
                      input logic lw, input logic [15:0] w,
                      input logic sw, input logic clr,
                      input logic [15:0] exp_ps);
    @(negedge clk);
    rst = r; valid_in = v; input_in = in; psum_in = ps;
    load_weight = lw; weight_in = w;
    switch_in = sw; clear_flag = clr;
    if (v && !r) q.push_back({exp_ps, in});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 32'(valid_out), 32'h0);
    chk({name, "_input"}, 32'(input_out), 32'h0);
    chk({name, "_psum"}, 32'(psum_out), 32'h0);
    chk({name, "_shadow"}, 32'(weight_out), 32'h0);
    chk({name, "_active"}, 32'(dut.active), 32'h0);
    chk({name, "_switch"}, 32'(switch_out), 32'h0);
    chk({name, "_sat"}, 32'(sat_flag), 32'h0);
  endtask

  // Monitor: each valid output cycle consumes one expected result
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(valid_out), 32'h0);
        end else begin
          e = q.pop_front();
          chk("psum_out", 32'(psum_out), 32'(e[31:16]));
          chk("input_out", 32'(input_out), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; valid_in = 0; input_in = 0; psum_in = 0;
    load_weight = 0; weight_in = 0; switch_in = 0; clear_flag = 0;

    // 1. reset and basic MAC
    step(1, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    chk_zero("reset");
    step(0, 0, 16'h0, 16'h0, 1, 16'h0200, 0, 0, 16'h0);
    chk("load1", 32'(weight_out), 32'h0200);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    chk("sw_out1", 32'(switch_out), 32'h1);
    step(0, 1, 16'h0180, 16'h0100, 0, 16'h0, 0, 0, 16'h0400);
    chk("valid_out1", 32'(valid_out), 32'h1);
    chk("sat1", 32'(sat_flag), 32'h0);
    chk("sw_out1_low", 32'(switch_out), 32'h0);

    // 2. double buffering
    step(0, 0, 16'h0, 16'h0, 1, 16'h0100, 0, 0, 16'h0);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    step(0, 1, 16'h0100, 16'h0, 1, 16'h0300, 0, 0, 16'h0100);
    chk("load2", 32'(weight_out), 32'h0300);
    step(0, 1, 16'h0100, 16'h0, 0, 16'h0, 1, 0, 16'h0100);
    chk("sw_out2", 32'(switch_out), 32'h1);
    step(0, 1, 16'h0100, 16'h0, 0, 16'h0, 0, 0, 16'h0300);
    chk("sw_out2_low", 32'(switch_out), 32'h0);

    // 3. negative and truncation toward -inf
    step(0, 0, 16'h0, 16'h0, 1, 16'h0080, 0, 0, 16'h0);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    step(0, 1, 16'hFF00, 16'h0, 0, 16'h0, 0, 0, 16'hFF80);
    step(0, 1, 16'hFFFF, 16'h0, 0, 16'h0, 0, 0, 16'hFFFF);
    chk("sat3", 32'(sat_flag), 32'h0);

    // 4. saturation and sticky flag
    step(0, 0, 16'h0, 16'h0, 1, 16'h0200, 0, 0, 16'h0);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    step(0, 1, 16'h7F00, 16'h0, 0, 16'h0, 0, 0, 16'h7FFF);
    chk("sat4a", 32'(sat_flag), 32'h1);
    step(0, 1, 16'h0100, 16'h8000, 0, 16'h0, 0, 0, 16'h8200);
    chk("sat4b", 32'(sat_flag), 32'h1);
    step(0, 1, 16'h7F00, 16'h0, 0, 16'h0, 0, 1, 16'h7FFF);
    chk("sat4_clr_clip", 32'(sat_flag), 32'h1);
    step(0, 1, 16'h0100, 16'h0, 0, 16'h0, 0, 1, 16'h0200);
    chk("sat4_clr", 32'(sat_flag), 32'h0);

    // 5. valid gating, clip while invalid, simultaneous load+switch
    step(0, 0, 16'h7F00, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    chk("gate_sat", 32'(sat_flag), 32'h0);
    chk("gate_psum", 32'(psum_out), 32'h0200);
    chk("gate_input", 32'(input_out), 32'h0100);
    chk("gate_valid", 32'(valid_out), 32'h0);
    step(0, 0, 16'h1234, 16'h5678, 1, 16'h0500, 0, 0, 16'h0);
    chk("gate_psum2", 32'(psum_out), 32'h0200);
    chk("gate_input2", 32'(input_out), 32'h0100);
    step(0, 0, 16'h0, 16'h0, 1, 16'h0700, 1, 0, 16'h0);
    chk("simul_shadow", 32'(weight_out), 32'h0700);
    chk("simul_active", 32'(dut.active), 32'h0500);
    step(0, 1, 16'h0100, 16'h0, 0, 16'h0, 0, 0, 16'h0500);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    step(0, 1, 16'h0100, 16'h0, 0, 16'h0, 0, 0, 16'h0700);

    // 6. reset mid-operation
    step(0, 1, 16'h0100, 16'h0, 1, 16'h0600, 0, 0, 16'h0700);
    step(1, 1, 16'h0100, 16'h0, 1, 16'h0400, 1, 0, 16'h0);
    chk_zero("midrst");
    step(0, 1, 16'h0100, 16'h0123, 0, 16'h0, 0, 0, 16'h0123);
    chk("post_rst_sat", 32'(sat_flag), 32'h0);

    idle();
    idle();
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
